// File: rtl/psum_pkg.sv
// Shared types and sizes for the GLB-side psum endpoint and its bank.
package psum_pkg;

   localparam int DATA_W = 21;
   localparam int DEPTH  = 64;
   localparam int ADDR_W = 6;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      DONE   = 2'd2
   } state_t;

   typedef logic signed [DATA_W-1:0] psum_t;

endpackage

// File: rtl/psum_bank_regfile.sv
// Psum bank: one synchronous write port, two asynchronous read ports
// (stream side and host side). Contents are deliberately not reset.
module psum_bank_regfile
   import psum_pkg::*;
(
   input  logic              clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  psum_t             i_wdata,
   input  logic [ADDR_W-1:0] i_raddr_s,
   output psum_t             o_rdata_s,
   input  logic [ADDR_W-1:0] i_raddr_h,
   output psum_t             o_rdata_h
);

   psum_t r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata_s = r_mem[i_raddr_s];
   assign o_rdata_h = r_mem[i_raddr_h];

endmodule

// File: rtl/psum_glb_port.sv
// GLB endpoint of the psum path: streams a pass of psums (or zeros) out to the
// router and writes each returning accumulated psum back to the same address.
//
//   state  | meaning
//   IDLE   | waiting for start; host may preload/drain the bank
//   ACTIVE | streaming out and absorbing returns; host writes are dropped
//   DONE   | one-cycle end-of-pass pulse; host writes allowed
module psum_glb_port
   import psum_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   len,
   input  logic              init_zero,
   output logic              out_valid,
   input  logic              out_ready,
   output psum_t             out_data,
   input  logic              in_valid,
   output logic              in_ready,
   input  psum_t             in_data,
   output logic              busy,
   output logic              done,
   input  logic              host_we,
   input  logic [ADDR_W-1:0] host_addr,
   input  psum_t             host_wdata,
   input  logic [ADDR_W-1:0] host_raddr,
   output psum_t             host_rdata
);

   localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W+1)'(DEPTH);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [ADDR_W:0]   r_rd_cnt;
   logic [ADDR_W:0]   r_wr_cnt;
   logic [ADDR_W:0]   r_len_q;
   logic [ADDR_W:0]   w_wr_cnt_nxt;
   logic [ADDR_W-1:0] r_base_q;
   logic              r_init_zero_q;
   logic              r_out_valid;
   psum_t             r_out_data;

   logic              w_active;
   logic              w_start;
   logic              w_load;
   logic              w_in_fire;
   logic [ADDR_W-1:0] w_rd_addr;
   logic [ADDR_W-1:0] w_wr_addr;
   psum_t             w_bank_rdata;
   logic              w_bank_we;
   logic [ADDR_W-1:0] w_bank_waddr;
   psum_t             w_bank_wdata;

   assign w_active     = (r_state == ACTIVE);
   assign w_start      = start && (r_state == IDLE);
   assign w_load       = w_active && (r_rd_cnt < r_len_q) && (!r_out_valid || out_ready);
   assign in_ready     = w_active && (r_wr_cnt < r_len_q);
   assign w_in_fire    = in_valid && in_ready;
   assign w_wr_cnt_nxt = r_wr_cnt + {{ADDR_W{1'b0}}, w_in_fire};

   // Address arithmetic is modulo DEPTH by truncation.
   assign w_rd_addr = r_base_q + r_rd_cnt[ADDR_W-1:0];
   assign w_wr_addr = r_base_q + r_wr_cnt[ADDR_W-1:0];

   assign busy      = w_active;
   assign done      = (r_state == DONE);
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;

   always_comb begin
      w_bank_we    = host_we;
      w_bank_waddr = host_addr;
      w_bank_wdata = host_wdata;
      if (w_active) begin
         w_bank_we    = w_in_fire;
         w_bank_waddr = w_wr_addr;
         w_bank_wdata = in_data;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (start) w_state_nxt = ACTIVE;
         // Look at the post-handshake count so done follows the last write directly.
         ACTIVE:  if (w_wr_cnt_nxt == r_len_q) w_state_nxt = DONE;
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rd_cnt      <= '0;
         r_wr_cnt      <= '0;
         r_len_q       <= '0;
         r_base_q      <= '0;
         r_init_zero_q <= 1'b0;
      end else if (w_start) begin
         r_rd_cnt      <= '0;
         r_wr_cnt      <= '0;
         r_len_q       <= (len > LEN_MAX) ? LEN_MAX : len;
         r_base_q      <= base_addr;
         r_init_zero_q <= init_zero;
      end else begin
         if (w_load) begin
            r_rd_cnt <= r_rd_cnt + (ADDR_W+1)'(1);
         end
         if (w_in_fire) begin
            r_wr_cnt <= w_wr_cnt_nxt;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
      end else if (w_load) begin
         r_out_valid <= 1'b1;
         r_out_data  <= r_init_zero_q ? psum_t'(0) : w_bank_rdata;
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   psum_bank_regfile u_bank (
      .clk       (clk),
      .i_we      (w_bank_we),
      .i_waddr   (w_bank_waddr),
      .i_wdata   (w_bank_wdata),
      .i_raddr_s (w_rd_addr),
      .o_rdata_s (w_bank_rdata),
      .i_raddr_h (host_raddr),
      .o_rdata_h (host_rdata)
   );

endmodule
